// File: rtl/ctrl_word_arbiter_if.sv
// Bus between two control-word requesters and the arbiter that owns the decoder's ctrl_in.
// Handshake: reqX is a level held until gntX; ctrlX must be stable while reqX is high;
// gntX is a one-cycle registered pulse marking the edge at which ctrlX was captured.
interface ctrl_word_arbiter_if #(parameter int WIDTH = 4);
  logic             req0;
  logic [WIDTH-1:0] ctrl0;
  logic             req1;
  logic [WIDTH-1:0] ctrl1;
  logic             gnt0;
  logic             gnt1;
  logic [WIDTH-1:0] ctrl_out;
  logic             ctrl_valid;
  logic             last_grant;
  logic             state_dbg;

  modport master (
    output req0, ctrl0, req1, ctrl1,
    input  gnt0, gnt1, ctrl_out, ctrl_valid, last_grant, state_dbg
  );

  modport slave (
    input  req0, ctrl0, req1, ctrl1,
    output gnt0, gnt1, ctrl_out, ctrl_valid, last_grant, state_dbg
  );
endinterface

// File: rtl/ctrl_word_arbiter.sv
// Round-robin arbiter sharing one control word between two requesters; a granted word
// is latched and held valid for HOLD_CYCLES cycles, then released (word itself is kept).
module ctrl_word_arbiter #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  ctrl_word_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);

  state_t           state, state_n;
  logic [7:0]       cnt, cnt_n;
  logic [WIDTH-1:0] word, word_n;
  logic             valid, valid_n;
  logic             g0, g0_n;
  logic             g1, g1_n;
  logic             last, last_n;
  logic             pick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      word  <= '0;
      valid <= 1'b0;
      g0    <= 1'b0;
      g1    <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      word  <= word_n;
      valid <= valid_n;
      g0    <= g0_n;
      g1    <= g1_n;
      last  <= last_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    word_n  = word;
    valid_n = valid;
    g0_n    = 1'b0;
    g1_n    = 1'b0;
    last_n  = last;
    // On a tie the requester that was not granted last wins; otherwise the lone requester.
    pick    = (bus.req0 && bus.req1) ? ~last : bus.req1;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_n = HOLD;
          cnt_n   = HOLD_INIT;
          valid_n = 1'b1;
          last_n  = pick;
          if (pick) begin
            word_n = bus.ctrl1;
            g1_n   = 1'b1;
          end else begin
            word_n = bus.ctrl0;
            g0_n   = 1'b1;
          end
        end
      end
      HOLD: begin
        if (cnt == 8'd0) begin
          state_n = IDLE;
          valid_n = 1'b0;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.gnt0       = g0;
  assign bus.gnt1       = g1;
  assign bus.ctrl_out   = word;
  assign bus.ctrl_valid = valid;
  assign bus.last_grant = last;
  assign bus.state_dbg  = (state == HOLD);

endmodule

// File: tb/tb_ctrl_word_arbiter.sv
// Self-checking bench for ctrl_word_arbiter: directed scenarios plus random traffic against
// a timestamp-based model, and a second HOLD_CYCLES=1 instance with both requests stuck high.
module tb_ctrl_word_arbiter;
  localparam int W = 4;
  localparam int H = 4;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic rst2 = 1'b0;
  always #5 clk = ~clk;

  ctrl_word_arbiter_if #(.WIDTH(W)) bus ();
  ctrl_word_arbiter_if #(.WIDTH(W)) bus2 ();

  ctrl_word_arbiter #(.WIDTH(W), .HOLD_CYCLES(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ctrl_word_arbiter #(.WIDTH(W), .HOLD_CYCLES(1)) dut_h1 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  int checks = 0;
  int fails  = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Time-based view: a grant at edge G blocks new grants until edge G+H+1 and keeps
  // the word valid for edges G..G+H-1.
  int         edge_no    = 0;
  int         grant_edge = -100;
  int         free_edge  = 0;
  bit         m_last     = 1'b1;
  bit         m_w;
  logic [W-1:0] m_word   = '0;
  bit         m_g0       = 1'b0;
  bit         m_g1       = 1'b0;
  bit         m_valid    = 1'b0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_no    = 0;
      grant_edge = -100;
      free_edge  = 0;
      m_last     = 1'b1;
      m_word     = '0;
      m_g0       = 1'b0;
      m_g1       = 1'b0;
      m_valid    = 1'b0;
      exp_q.delete();
    end else begin
      edge_no++;
      m_g0 = 1'b0;
      m_g1 = 1'b0;
      if (edge_no >= free_edge && (bus.req0 || bus.req1)) begin
        m_w        = (bus.req0 && bus.req1) ? !m_last : bus.req1;
        m_word     = m_w ? bus.ctrl1 : bus.ctrl0;
        m_g0       = !m_w;
        m_g1       = m_w;
        m_last     = m_w;
        grant_edge = edge_no;
        free_edge  = edge_no + H + 1;
        exp_q.push_back(m_word);
      end
      m_valid = (edge_no - grant_edge) < H;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("gnt0", bus.gnt0, m_g0);
      chk("gnt1", bus.gnt1, m_g1);
      chk("ctrl_out", bus.ctrl_out, m_word);
      chk("ctrl_valid", bus.ctrl_valid, m_valid);
      chk("last_grant", bus.last_grant, m_last);
      chk("state_dbg", bus.state_dbg, m_valid);
      chk("gnt_exclusive", bus.gnt0 & bus.gnt1, 1'b0);
      if (bus.gnt0 || bus.gnt1) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL sb_word: grant seen with word %0h but none expected at %0t",
                   bus.ctrl_out, $time);
        end else begin
          chk("sb_word", bus.ctrl_out, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- HOLD_CYCLES=1 instance, both requests stuck high ----------------
  int k2 = 0;
  always @(posedge clk) begin
    if (!rst2 && k2 < 1000) k2++;
  end

  always @(negedge clk) begin
    if (k2 > 0 && k2 <= 40) begin
      chk("h1_valid", bus2.ctrl_valid, 1'((k2 % 2) == 1));
      chk("h1_gnt0", bus2.gnt0, 1'((k2 % 4) == 1));
      chk("h1_gnt1", bus2.gnt1, 1'((k2 % 4) == 3));
      chk("h1_word", bus2.ctrl_out, ((((k2 - 1) / 2) % 2) == 0) ? 32'h3 : 32'hc);
      chk("h1_last", bus2.last_grant, 1'((((k2 - 1) / 2) % 2) == 1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step_req(input logic r, input logic g, output logic r_n,
                          inout logic [W-1:0] c);
    r_n = r;
    if (r) begin
      if (g) begin
        if ($urandom_range(0, 1) == 0) r_n = 1'b0;
      end else if ($urandom_range(0, 15) == 0) begin
        r_n = 1'b0;
      end
    end else begin
      c = W'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) r_n = 1'b1;
    end
  endtask

  task automatic idle_both(input int n);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  int           vcount;
  int           ng;
  int           seen_at;
  logic [W-1:0] words[8];
  int           at[8];
  logic         r_tmp;
  logic [W-1:0] c_tmp;

  initial begin
    bus.req0   = 1'b0;
    bus.req1   = 1'b0;
    bus.ctrl0  = '0;
    bus.ctrl1  = '0;
    bus2.req0  = 1'b1;
    bus2.req1  = 1'b1;
    bus2.ctrl0 = 4'b0011;
    bus2.ctrl1 = 4'b1100;
    #1;
    rst  = 1'b1;
    rst2 = 1'b1;
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    rst2 = 1'b0;
    cmp_on = 1'b1;
    repeat (2) @(negedge clk);

    // Single request, word 1010
    bus.ctrl0 = 4'b1010;
    bus.req0  = 1'b1;
    @(posedge clk);
    #1;
    chk("single_gnt0", bus.gnt0, 1'b1);
    chk("single_word", bus.ctrl_out, 4'b1010);
    @(negedge clk);
    bus.req0 = 1'b0;
    vcount = int'(bus.ctrl_valid);
    repeat (7) begin
      @(negedge clk);
      vcount += int'(bus.ctrl_valid);
    end
    chk("single_valid_cycles", vcount, 4);
    chk("single_word_kept", bus.ctrl_out, 4'b1010);

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_ctrl_out", bus.ctrl_out, 4'b0000);
    chk("rst_valid", bus.ctrl_valid, 1'b0);
    chk("rst_gnt0", bus.gnt0, 1'b0);
    chk("rst_gnt1", bus.gnt1, 1'b0);
    chk("rst_last", bus.last_grant, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Tie and fairness
    bus.ctrl0 = 4'b0110;
    bus.ctrl1 = 4'b1111;
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    ng = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if ((bus.gnt0 || bus.gnt1) && ng < 8) begin
        words[ng] = bus.ctrl_out;
        at[ng]    = i;
        ng++;
      end
    end
    chk("tie_count", ng, 5);
    chk("tie_w0", words[0], 4'b0110);
    chk("tie_w1", words[1], 4'b1111);
    chk("tie_w2", words[2], 4'b0110);
    chk("tie_w3", words[3], 4'b1111);
    chk("tie_space01", at[1] - at[0], 5);
    chk("tie_space12", at[2] - at[1], 5);
    idle_both(8);

    // Request arriving during HOLD
    bus.ctrl0 = 4'b1010;
    bus.req0  = 1'b1;
    @(negedge clk);
    chk("dur_gnt0", bus.gnt0, 1'b1);
    bus.req0 = 1'b0;
    @(negedge clk);
    bus.ctrl1 = 4'b0001;
    bus.req1  = 1'b1;
    seen_at = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.gnt1) begin
        seen_at = i;
        bus.req1 = 1'b0;
        break;
      end
    end
    chk("dur_gnt1_delay", seen_at, 4);
    chk("dur_word", bus.ctrl_out, 4'b0001);
    idle_both(8);

    // Reset in the second HOLD cycle of a grant to requester 1
    bus.ctrl1 = 4'b1111;
    bus.req1  = 1'b1;
    @(negedge clk);
    chk("mid_gnt1", bus.gnt1, 1'b1);
    bus.req1 = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_word", bus.ctrl_out, 4'b0000);
    chk("mid_rst_valid", bus.ctrl_valid, 1'b0);
    chk("mid_rst_last", bus.last_grant, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    bus.ctrl0 = 4'b0110;
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_next_gnt0", bus.gnt0, 1'b1);
    @(negedge clk);
    idle_both(8);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      c_tmp = bus.ctrl0;
      step_req(bus.req0, bus.gnt0, r_tmp, c_tmp);
      bus.ctrl0 = c_tmp;
      bus.req0  = r_tmp;
      c_tmp = bus.ctrl1;
      step_req(bus.req1, bus.gnt1, r_tmp, c_tmp);
      bus.ctrl1 = c_tmp;
      bus.req1  = r_tmp;
      @(negedge clk);
    end
    idle_both(8);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
